commit_monitor: RTL and testbench
=================================

COMMIT_MONITOR -- requirements
Module: commit_monitor

Interface
REQ-001 SHALL have parameter COMMIT_WIDTH, default 2: number of commit lanes.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of every counter.
REQ-003 SHALL have port clk  in  1: single clock, rising edge.
REQ-004 SHALL have port negResetIn  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1: one-cycle pulse to begin a measurement run.
REQ-006 SHALL have port clear  in  1: one-cycle pulse to return to IDLE.
REQ-007 SHALL have port enablePcGoal  in  1: goal detection enable.
REQ-008 SHALL have port pcGoal  in  32: goal PC.
REQ-009 SHALL have port maxCycles  in  CNT_WIDTH: run limit; 0 = unlimited.
REQ-010 SHALL have port commit  in  COMMIT_WIDTH: per-lane commit valid.
REQ-011 SHALL have port firstMicroOp  in  COMMIT_WIDTH: per-lane flag, micro-op index 0 (i.e. opId.mid == 0).
REQ-012 SHALL have port commitPC  in  COMMIT_WIDTH x 32: per-lane committed PC.
REQ-013 SHALL have port busy  out  1: FSM in RUN.
REQ-014 SHALL have port done  out  1: FSM in DONE.
REQ-015 SHALL have port doneReason  out  2: 0 NONE, 1 GOAL, 2 TIMEOUT.
REQ-016 SHALL have port cycleCount, numMicroOp, numRiscvOp  out  CNT_WIDTH each: run statistics.
REQ-017 SHALL have port lastCommittedPC  out  32: PC of most recent committed op.
REQ-018 SHALL have port overflow, laneOrderError  out  1 each: sticky flags.

Function
REQ-019 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on goal or timeout; DONE->IDLE and RUN->IDLE on clear; start outside IDLE ignored.
REQ-020 SHALL give clear priority over start when both asserted in the same cycle.
REQ-021 SHALL, on the IDLE->RUN edge, zero all counters, lastCommittedPC, doneReason and sticky flags.
REQ-022 SHALL, each RUN cycle, increment cycleCount by 1, numMicroOp by popcount(commit), numRiscvOp by popcount(commit & firstMicroOp); results visible next cycle.
REQ-023 SHALL saturate each counter at all-ones and set overflow if any increment would exceed it.
REQ-024 SHALL update lastCommittedPC in RUN with commitPC of the highest-indexed lane having commit=1; hold when no lane commits.
REQ-025 SHALL detect goal when enablePcGoal=1 and any committing lane's commitPC equals pcGoal in RUN.
REQ-026 SHALL detect timeout when maxCycles!=0 and the incremented cycleCount equals maxCycles.
REQ-027 SHALL count all commits of the terminating cycle; done asserted the following cycle.
REQ-028 SHALL report GOAL when goal and timeout coincide.
REQ-029 SHALL set laneOrderError if commit has a 1 above a 0 (non-contiguous lanes); SHALL still count every set lane.
REQ-030 SHALL hold all counters and outputs unchanged in DONE and IDLE; counters/lastCommittedPC/flags stay readable in IDLE after clear, until the next start.
REQ-031 SHALL ignore commit inputs outside RUN.

Reset
REQ-032 SHALL, on negResetIn low, immediately enter IDLE with busy=0, done=0, doneReason=0, all counters 0, lastCommittedPC=0, overflow=0, laneOrderError=0.
REQ-033 SHALL, on reset during RUN, abandon the run with no DONE transition; release resumes in IDLE.

Structure
REQ-034 SHALL place state enum, doneReason enum and CNT_WIDTH default in shared package CommitMonitorTypes.
REQ-035 SHALL use one sub-module, commit_pop_count (COMMIT_WIDTH-bit population count), instantiated twice.
REQ-036 SHALL register all outputs; no combinational input-to-output path.

Verification
REQ-037 SHALL cover: start, 10 cycles commit=2'b11, firstMicroOp=2'b01 -> cycleCount=10, numMicroOp=20, numRiscvOp=10.
REQ-038 SHALL cover: pcGoal=0x00001000, lane1 commits 0x00001000 at cycle 5 -> done next cycle, doneReason=1, lastCommittedPC=0x00001000, cycleCount=5.
REQ-039 SHALL cover: maxCycles=4, no goal -> done after 4 RUN cycles, doneReason=2; maxCycles=0 -> runs 1000 cycles without done.
REQ-040 SHALL cover: goal at cycle maxCycles=8 -> doneReason=1; start+clear same cycle -> stays IDLE.
REQ-041 SHALL cover: CNT_WIDTH=4, 20 cycles commit=2'b11 -> numMicroOp=15, overflow=1; commit=2'b10 -> laneOrderError=1, numMicroOp+=1.
REQ-042 SHALL cover: negResetIn low mid-RUN -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/commit_monitor_pkg.sv
// Shared types for the commit monitor:
// FSM states, done reasons, default counter width.
package CommitMonitorTypes;

  localparam int DEF_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RSN_NONE    = 2'd0,
    RSN_GOAL    = 2'd1,
    RSN_TIMEOUT = 2'd2
  } reason_e;

endpackage

// File: rtl/commit_pop_count.sv
// Population count of a commit lane vector.
// Pure combinational helper.
module commit_pop_count #(
  parameter int W  = 2,
  parameter int PW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [PW-1:0] count
);

  // Sum of set bits across all lanes
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + PW'(bits[i]);
    end
  end

endmodule

// File: rtl/commit_monitor.sv
// Commit-stream run monitor: counts cycles and
// retired ops, stops on goal PC or cycle limit.
module commit_monitor
  import CommitMonitorTypes::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         negResetIn,
  input  logic                         start,
  input  logic                         clear,
  input  logic                         enablePcGoal,
  input  logic [31:0]                  pcGoal,
  input  logic [CNT_WIDTH-1:0]         maxCycles,
  input  logic [COMMIT_WIDTH-1:0]      commit,
  input  logic [COMMIT_WIDTH-1:0]      firstMicroOp,
  input  logic [COMMIT_WIDTH-1:0][31:0] commitPC,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   doneReason,
  output logic [CNT_WIDTH-1:0]         cycleCount,
  output logic [CNT_WIDTH-1:0]         numMicroOp,
  output logic [CNT_WIDTH-1:0]         numRiscvOp,
  output logic [31:0]                  lastCommittedPC,
  output logic                         overflow,
  output logic                         laneOrderError
);

  localparam int PW = $clog2(COMMIT_WIDTH + 1);

  state_e                state;
  state_e                state_nx;
  reason_e               reason;
  logic [PW-1:0]         uop_inc;
  logic [PW-1:0]         rv_inc;
  logic [CNT_WIDTH:0]    cyc_sum;
  logic [CNT_WIDTH:0]    uop_sum;
  logic [CNT_WIDTH:0]    rv_sum;
  logic [CNT_WIDTH-1:0]  cyc_nx;
  logic [CNT_WIDTH-1:0]  uop_nx;
  logic [CNT_WIDTH-1:0]  rv_nx;
  logic                  ovf_nx;
  logic                  goal;
  logic                  timeout;
  logic                  order_bad;
  logic                  run_start;
  logic [31:0]           pc_sel;
  logic [COMMIT_WIDTH-1:0] rv_lanes;

  assign rv_lanes = commit & firstMicroOp;

  commit_pop_count #(.W(COMMIT_WIDTH), .PW(PW)) u_pop_uop (
    .bits  (commit),
    .count (uop_inc)
  );

  commit_pop_count #(.W(COMMIT_WIDTH), .PW(PW)) u_pop_rv (
    .bits  (rv_lanes),
    .count (rv_inc)
  );

  // Saturating next values for the three counters
  always_comb begin
    cyc_sum = {1'b0, cycleCount} + (CNT_WIDTH+1)'(1);
    uop_sum = {1'b0, numMicroOp} + (CNT_WIDTH+1)'(uop_inc);
    rv_sum  = {1'b0, numRiscvOp} + (CNT_WIDTH+1)'(rv_inc);
    cyc_nx  = cyc_sum[CNT_WIDTH] ? '1 : cyc_sum[CNT_WIDTH-1:0];
    uop_nx  = uop_sum[CNT_WIDTH] ? '1 : uop_sum[CNT_WIDTH-1:0];
    rv_nx   = rv_sum[CNT_WIDTH]  ? '1 : rv_sum[CNT_WIDTH-1:0];
    ovf_nx  = cyc_sum[CNT_WIDTH] | uop_sum[CNT_WIDTH]
            | rv_sum[CNT_WIDTH];
  end

  // Highest committing lane wins the PC; any lane may hit goal
  always_comb begin
    pc_sel = lastCommittedPC;
    goal   = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (commit[i]) begin
        pc_sel = commitPC[i];
        if (enablePcGoal && (commitPC[i] == pcGoal)) begin
          goal = 1'b1;
        end
      end
    end
  end

  // A set lane above a clear one means commit+1 shares a bit with it
  assign order_bad = |(commit & (commit + COMMIT_WIDTH'(1)));
  assign timeout   = (maxCycles != '0) && (cyc_nx == maxCycles);
  assign run_start = (state == ST_IDLE) && start && !clear;

  // State register
  always_ff @(posedge clk or negedge negResetIn) begin
    if (!negResetIn) state <= ST_IDLE;
    else             state <= state_nx;
  end

  // Next-state decode; clear beats start and termination
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == ST_IDLE): if (run_start) state_nx = ST_RUN;
      (state == ST_RUN): begin
        if (clear)                state_nx = ST_IDLE;
        else if (goal || timeout) state_nx = ST_DONE;
      end
      (state == ST_DONE): if (clear) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  assign doneReason = reason;

  // Run statistics: cleared on start, updated only while running
  always_ff @(posedge clk or negedge negResetIn) begin
    if (!negResetIn) begin
      cycleCount      <= '0;
      numMicroOp      <= '0;
      numRiscvOp      <= '0;
      lastCommittedPC <= '0;
      overflow        <= 1'b0;
      laneOrderError  <= 1'b0;
      reason          <= RSN_NONE;
    end else if (run_start) begin
      cycleCount      <= '0;
      numMicroOp      <= '0;
      numRiscvOp      <= '0;
      lastCommittedPC <= '0;
      overflow        <= 1'b0;
      laneOrderError  <= 1'b0;
      reason          <= RSN_NONE;
    end else if (state == ST_RUN) begin
      cycleCount      <= cyc_nx;
      numMicroOp      <= uop_nx;
      numRiscvOp      <= rv_nx;
      lastCommittedPC <= pc_sel;
      if (ovf_nx)    overflow       <= 1'b1;
      if (order_bad) laneOrderError <= 1'b1;
      if (!clear) begin
        if (goal)         reason <= RSN_GOAL;
        else if (timeout) reason <= RSN_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor: 32-bit and
// 4-bit counter instances checked against a model.
module tb_commit_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic clear = 1'b0;
  logic en_goal = 1'b0;
  logic [31:0] pc_goal = '0;
  logic [31:0] max_cycles = '0;
  logic [1:0] commit = '0;
  logic [1:0] first = '0;
  logic [1:0][31:0] pc = '0;

  logic a_busy, a_done, a_ovf, a_loe;
  logic [1:0] a_rsn;
  logic [31:0] a_cyc, a_uop, a_rv, a_lpc;
  logic b_busy, b_done, b_ovf, b_loe;
  logic [1:0] b_rsn;
  logic [3:0] b_cyc, b_uop, b_rv;
  logic [31:0] b_lpc;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  commit_monitor #(.COMMIT_WIDTH(2), .CNT_WIDTH(32)) dut32 (
    .clk(clk), .negResetIn(rst_n), .start(start), .clear(clear),
    .enablePcGoal(en_goal), .pcGoal(pc_goal), .maxCycles(max_cycles),
    .commit(commit), .firstMicroOp(first), .commitPC(pc),
    .busy(a_busy), .done(a_done), .doneReason(a_rsn),
    .cycleCount(a_cyc), .numMicroOp(a_uop), .numRiscvOp(a_rv),
    .lastCommittedPC(a_lpc), .overflow(a_ovf), .laneOrderError(a_loe)
  );

  commit_monitor #(.COMMIT_WIDTH(2), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .negResetIn(rst_n), .start(start), .clear(clear),
    .enablePcGoal(en_goal), .pcGoal(pc_goal),
    .maxCycles(max_cycles[3:0]),
    .commit(commit), .firstMicroOp(first), .commitPC(pc),
    .busy(b_busy), .done(b_done), .doneReason(b_rsn),
    .cycleCount(b_cyc), .numMicroOp(b_uop), .numRiscvOp(b_rv),
    .lastCommittedPC(b_lpc), .overflow(b_ovf), .laneOrderError(b_loe)
  );

  // st: 0 idle, 1 run, 2 done; rsn: 0 none, 1 goal, 2 timeout
  typedef struct packed {
    logic [1:0]  st;
    logic [63:0] cyc;
    logic [63:0] nmo;
    logic [63:0] nro;
    logic [31:0] lpc;
    logic        ovf;
    logic        loe;
    logic [1:0]  rsn;
  } mdl_t;

  mdl_t m32 = '0;
  mdl_t m4 = '0;

  function automatic logic [63:0] sat_add(logic [63:0] a,
      logic [63:0] b, logic [63:0] top, ref bit o);
    if (a + b > top) begin
      o = 1'b1;
      return top;
    end
    return a + b;
  endfunction

  function automatic mdl_t step(mdl_t m, int w);
    mdl_t n = m;
    logic [63:0] top = (64'd1 << w) - 64'd1;
    logic [63:0] mx = {32'd0, max_cycles} & top;
    int nu = 0;
    int nr = 0;
    bit gl = 0;
    bit hole = 0;
    bit o = 0;
    if (m.st == 2'd0) begin
      if (!clear && start) begin
        n = '0;
        n.st = 2'd1;
      end
    end else if (m.st == 2'd1) begin
      for (int i = 0; i < 2; i++) begin
        if (!commit[i]) hole = 1;
        else begin
          nu++;
          if (first[i]) nr++;
          n.lpc = pc[i];
          if (en_goal && pc[i] == pc_goal) gl = 1;
          if (hole) n.loe = 1'b1;
        end
      end
      n.cyc = sat_add(m.cyc, 64'd1, top, o);
      n.nmo = sat_add(m.nmo, 64'(nu), top, o);
      n.nro = sat_add(m.nro, 64'(nr), top, o);
      if (o) n.ovf = 1'b1;
      if (clear) n.st = 2'd0;
      else if (gl) begin
        n.st = 2'd2;
        n.rsn = 2'd1;
      end else if (mx != 0 && n.cyc == mx) begin
        n.st = 2'd2;
        n.rsn = 2'd2;
      end
    end else begin
      if (clear) n.st = 2'd0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m32 = '0;
      m4 = '0;
    end else begin
      m32 = step(m32, 32);
      m4 = step(m4, 4);
    end
  end

  task automatic cmp(string tag, mdl_t m, logic bsy, logic dn,
      logic [1:0] rs, logic [63:0] c, logic [63:0] u,
      logic [63:0] r, logic [31:0] l, logic o, logic e);
    compared++;
    if (bsy !== (m.st == 2'd1) || dn !== (m.st == 2'd2) ||
        rs !== m.rsn || c !== m.cyc || u !== m.nmo ||
        r !== m.nro || l !== m.lpc || o !== m.ovf || e !== m.loe) begin
      mismatched++;
      $display("FAIL %s t=%0t got b=%b d=%b r=%0d c=%0d u=%0d rv=%0d pc=%h o=%b e=%b need b=%b d=%b r=%0d c=%0d u=%0d rv=%0d pc=%h o=%b e=%b",
        tag, $time, bsy, dn, rs, c, u, r, l, o, e,
        m.st == 2'd1, m.st == 2'd2, m.rsn, m.cyc, m.nmo, m.nro,
        m.lpc, m.ovf, m.loe);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model32", m32, a_busy, a_done, a_rsn, 64'(a_cyc),
          64'(a_uop), 64'(a_rv), a_lpc, a_ovf, a_loe);
      cmp("model4", m4, b_busy, b_done, b_rsn, 64'(b_cyc),
          64'(b_uop), 64'(b_rv), b_lpc, b_ovf, b_loe);
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s t=%0t got %0d need %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_cyc", 64'(a_cyc), 64'd0);
    chk("rst_lpc", 64'(a_lpc), 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Ten dual-lane cycles, lane 0 first micro-op only
    pulse_start();
    commit = 2'b11;
    first = 2'b01;
    repeat (10) tick();
    chk("s1_cyc", 64'(a_cyc), 64'd10);
    chk("s1_uop", 64'(a_uop), 64'd20);
    chk("s1_rv", 64'(a_rv), 64'd10);
    chk("s1_uop4", 64'(b_uop), 64'd15);
    chk("s1_ovf4", 64'(b_ovf), 64'd1);
    commit = 2'b00;
    first = 2'b00;
    pulse_clear();
    chk("s1_idle", 64'(a_busy), 64'd0);

    // Goal hit on lane 1 in the fifth run cycle
    en_goal = 1'b1;
    pc_goal = 32'h0000_1000;
    pulse_start();
    for (int k = 1; k <= 4; k++) begin
      commit = 2'b01;
      pc[0] = 32'h100 + 32'(k * 4);
      pc[1] = '0;
      tick();
    end
    commit = 2'b11;
    pc[0] = 32'h0000_0ffc;
    pc[1] = 32'h0000_1000;
    tick();
    commit = 2'b00;
    chk("s2_done", 64'(a_done), 64'd1);
    chk("s2_rsn", 64'(a_rsn), 64'd1);
    chk("s2_lpc", 64'(a_lpc), 64'h1000);
    chk("s2_cyc", 64'(a_cyc), 64'd5);
    repeat (3) tick();
    chk("s2_hold", 64'(a_cyc), 64'd5);
    pulse_clear();

    // Timeout after four run cycles
    en_goal = 1'b0;
    max_cycles = 32'd4;
    pulse_start();
    repeat (3) tick();
    chk("s3_busy", 64'(a_busy), 64'd1);
    tick();
    chk("s3_done", 64'(a_done), 64'd1);
    chk("s3_rsn", 64'(a_rsn), 64'd2);
    chk("s3_cyc", 64'(a_cyc), 64'd4);
    pulse_clear();

    // Unlimited run
    max_cycles = 32'd0;
    commit = 2'b01;
    first = 2'b01;
    pulse_start();
    repeat (1000) tick();
    chk("s4_busy", 64'(a_busy), 64'd1);
    chk("s4_cyc", 64'(a_cyc), 64'd1000);
    chk("s4_cyc4", 64'(b_cyc), 64'd15);
    commit = 2'b00;
    first = 2'b00;
    pulse_clear();

    // Goal and timeout coincide on cycle 8
    max_cycles = 32'd8;
    en_goal = 1'b1;
    pc_goal = 32'h0000_2000;
    pulse_start();
    repeat (7) tick();
    commit = 2'b01;
    pc[0] = 32'h0000_2000;
    tick();
    commit = 2'b00;
    chk("s5_rsn", 64'(a_rsn), 64'd1);
    chk("s5_cyc", 64'(a_cyc), 64'd8);
    pulse_clear();

    // start and clear together from idle
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    tick();
    chk("s6_busy", 64'(a_busy), 64'd0);

    // Saturation in the narrow instance, then lane order error
    max_cycles = 32'd0;
    en_goal = 1'b0;
    pulse_start();
    commit = 2'b11;
    repeat (20) tick();
    chk("s7_uop4", 64'(b_uop), 64'd15);
    chk("s7_cyc4", 64'(b_cyc), 64'd15);
    chk("s7_ovf4", 64'(b_ovf), 64'd1);
    chk("s7_ovf32", 64'(a_ovf), 64'd0);
    commit = 2'b00;
    pulse_clear();
    pulse_start();
    commit = 2'b10;
    pc[1] = 32'h0000_3000;
    tick();
    commit = 2'b00;
    tick();
    chk("s7_loe", 64'(a_loe), 64'd1);
    chk("s7_uop", 64'(a_uop), 64'd1);
    chk("s7_lpc", 64'(a_lpc), 64'h3000);
    pulse_clear();

    // Asynchronous reset in the middle of a run
    pulse_start();
    commit = 2'b11;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("s8_busy", 64'(a_busy), 64'd0);
    chk("s8_cyc", 64'(a_cyc), 64'd0);
    chk("s8_uop", 64'(a_uop), 64'd0);
    chk("s8_cyc4", 64'(b_cyc), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("s8_idle", 64'(a_busy), 64'd0);
    chk("s8_cnt", 64'(a_cyc), 64'd0);
    commit = 2'b00;
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
